// File: rtl/tv_vram_arbiter.sv
// Single-port video RAM arbiter: strict-priority TV bitmap prefetch plus a host req/ack port.
// Optional build macro TVARB_BLANK_ONLY_EN limits host accesses to vertical blanking.
module tv_vram_arbiter #(
   parameter int unsigned ADDR_W         = 14,
   parameter int unsigned DATA_W         = 16,
   parameter int unsigned WORDS_PER_LINE = 32,
   parameter int unsigned ACTIVE_LINES   = 288,
   parameter int unsigned LAST_X         = 639,
   parameter int unsigned LAST_Y         = 308
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clk10,
   input  logic [9:0]        xpos,
   input  logic [8:0]        ypos,
   input  logic              host_req,
   input  logic              host_we,
   input  logic [ADDR_W-1:0] host_addr,
   input  logic [DATA_W-1:0] host_wdata,
   output logic              host_ack,
   output logic [DATA_W-1:0] host_rdata,
   output logic [ADDR_W-1:0] ram_addr,
   output logic              ram_we,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_rdata,
   output logic [DATA_W-1:0] vid_word,
   output logic              vid_load
);

   localparam int unsigned WordBits = $clog2(WORDS_PER_LINE);
   localparam int unsigned LineBits = ADDR_W - WordBits;

   typedef enum logic [2:0] {
      StIdle, StVidRd, StVidCap, StHostRd, StHostCap, StHostWr
   } state_e;

   state_e              state_q, state_d;
   logic                vid_pend_q;
   logic [ADDR_W-1:0]   vid_addr_q;
   logic [DATA_W-1:0]   vid_next_q;
   logic [DATA_W-1:0]   host_rdata_q;

   logic [8:0]          next_line;
   logic                line_trig, word_trig, trig, handoff, host_ok;
   logic [8:0]          line_sel;
   logic [WordBits-1:0] word_sel;
   logic [ADDR_W-1:0]   trig_addr;
   logic                we_raw, ack_raw;

   assign next_line = (ypos == 9'(LAST_Y)) ? 9'd0 : ypos + 9'd1;

   // Word 0 of the next line is fetched at the end of the current one; words 1..31 mid-line.
   assign line_trig = clk10 && (xpos == 10'(LAST_X - 7)) && (next_line < 9'(ACTIVE_LINES));
   assign word_trig = clk10 && (ypos < 9'(ACTIVE_LINES)) && (xpos[3:0] == 4'd8) &&
                      (xpos[9:4] < 6'(WORDS_PER_LINE - 1));
   assign trig      = line_trig || word_trig;
   assign line_sel  = line_trig ? next_line : ypos;
   assign word_sel  = line_trig ? '0 : WordBits'(xpos[9:4] + 6'd1);
   assign trig_addr = {LineBits'(line_sel), word_sel};

   assign handoff = clk10 &&
                    (((xpos == 10'(LAST_X)) && (next_line < 9'(ACTIVE_LINES))) ||
                     ((ypos < 9'(ACTIVE_LINES)) && (xpos[3:0] == 4'hf) &&
                      (xpos < 10'(WORDS_PER_LINE * DATA_W - 1))));

`ifdef TVARB_BLANK_ONLY_EN
   assign host_ok = (ypos >= 9'(ACTIVE_LINES));
`else
   assign host_ok = 1'b1;
`endif

   always_comb begin
      state_d  = state_q;
      ram_addr = '0;
      we_raw   = 1'b0;
      ack_raw  = 1'b0;
      case (state_q)
         StIdle: begin
            // A trigger arriving this very cycle already beats a waiting host request.
            if (vid_pend_q || trig) begin
               state_d = StVidRd;
            end else if (host_req && host_ok) begin
               state_d = host_we ? StHostWr : StHostRd;
            end
         end
         StVidRd: begin
            ram_addr = vid_addr_q;
            state_d  = StVidCap;
         end
         StVidCap: begin
            ram_addr = vid_addr_q;
            state_d  = StIdle;
         end
         StHostRd: begin
            ram_addr = host_addr;
            state_d  = StHostCap;
         end
         StHostCap: begin
            ram_addr = host_addr;
            ack_raw  = 1'b1;
            state_d  = StIdle;
         end
         StHostWr: begin
            ram_addr = host_addr;
            we_raw   = 1'b1;
            ack_raw  = 1'b1;
            state_d  = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // Gating with rst_n keeps an access caught by reset from writing or acknowledging.
   assign ram_we     = we_raw && rst_n;
   assign host_ack   = ack_raw && rst_n;
   assign ram_wdata  = host_wdata;
   assign host_rdata = (state_q == StHostCap) ? ram_rdata : host_rdata_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= StIdle;
         vid_pend_q   <= 1'b0;
         vid_addr_q   <= '0;
         vid_next_q   <= '0;
         host_rdata_q <= '0;
         vid_word     <= '0;
         vid_load     <= 1'b0;
      end else begin
         state_q <= state_d;
         if (trig) begin
            vid_pend_q <= 1'b1;
            vid_addr_q <= trig_addr;
         end else if (state_q == StVidRd) begin
            vid_pend_q <= 1'b0;
         end
         if (state_q == StVidCap) vid_next_q <= ram_rdata;
         if (state_q == StHostCap) host_rdata_q <= ram_rdata;
         if (handoff) vid_word <= vid_next_q;
         vid_load <= handoff;
      end
   end

endmodule

// File: tb/tb_tv_vram_arbiter.sv
// Randomized self-checking bench for tv_vram_arbiter with a behavioural RAM/video/host model.
// Honours TVARB_BLANK_ONLY_EN when the design is built with it.
module tb_tv_vram_arbiter;

   localparam int ActiveLines = 288;
   localparam int LastX       = 639;
   localparam int LastY       = 308;
   localparam int WordsPerLn  = 32;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        clk10 = 1'b0;
   logic [9:0]  xpos = '0;
   logic [8:0]  ypos = '0;
   logic        host_req = 1'b0;
   logic        host_we = 1'b0;
   logic [13:0] host_addr = '0;
   logic [15:0] host_wdata = '0;
   logic        host_ack;
   logic [15:0] host_rdata;
   logic [13:0] ram_addr;
   logic        ram_we;
   logic [15:0] ram_wdata;
   logic [15:0] ram_rdata;
   logic [15:0] vid_word;
   logic        vid_load;

   logic        init_we = 1'b0;
   logic [13:0] init_addr = '0;
   logic [15:0] init_data = '0;
   logic [15:0] ram [0:16383];
   logic [15:0] ref_mem [0:16383];
   logic [15:0] exp_word, exp_next;
   logic [13:0] wq [$];
   int          n_vec, n_err;
   bit          line_done;

   tv_vram_arbiter dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .clk10      (clk10),
      .xpos       (xpos),
      .ypos       (ypos),
      .host_req   (host_req),
      .host_we    (host_we),
      .host_addr  (host_addr),
      .host_wdata (host_wdata),
      .host_ack   (host_ack),
      .host_rdata (host_rdata),
      .ram_addr   (ram_addr),
      .ram_we     (ram_we),
      .ram_wdata  (ram_wdata),
      .ram_rdata  (ram_rdata),
      .vid_word   (vid_word),
      .vid_load   (vid_load)
   );

   always #10 clk = ~clk;

   // Synchronous single-port RAM, one-cycle read latency; init port used only during reset.
   always @(posedge clk) begin
      if (init_we) ram[init_addr] <= init_data;
      else if (ram_we) ram[ram_addr] <= ram_wdata;
      ram_rdata <= ram[ram_addr];
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic bit host_allowed(input int y);
`ifdef TVARB_BLANK_ONLY_EN
      return y >= ActiveLines;
`else
      return (y >= 0);
`endif
   endfunction

   // One clock cycle of timing-generator input; predicts fetch/handoff from the pixel rules.
   task automatic tick(input bit c10, input int x, input int y);
      bit trig, hand;
      int ny, line, word;
      clk10 = c10;
      xpos  = 10'(x);
      ypos  = 9'(y);
      ny    = (y == LastY) ? 0 : y + 1;
      trig  = 0;
      hand  = 0;
      line  = 0;
      word  = 0;
      if (c10) begin
         if (x == LastX - 7 && ny < ActiveLines) begin
            trig = 1; line = ny; word = 0;
         end else if (y < ActiveLines && x >= 8 && x <= 16 * 30 + 8 && x % 16 == 8) begin
            trig = 1; line = y; word = (x - 8) / 16 + 1;
         end
         if ((x == LastX && ny < ActiveLines) || (y < ActiveLines && x % 16 == 15 && x < 511))
            hand = 1;
      end
      @(posedge clk); #1;
      clk10 = 1'b0;
      if (hand) exp_word = exp_next;
      if (trig) exp_next = ref_mem[line * WordsPerLn + word];
      chk("vid_load", {31'd0, vid_load}, {31'd0, hand});
      chk("vid_word", {16'd0, vid_word}, {16'd0, exp_word});
   endtask

   task automatic sweep(input int y);
      for (int x = 0; x <= LastX; x++) begin
         tick(1'b1, x, y);
         repeat (4) tick(1'b0, x, y);
      end
   endtask

   task automatic host_txn(input logic we, input logic [13:0] addr, input logic [15:0] wdata);
      bit got;
      got        = 0;
      host_req   = 1'b1;
      host_we    = we;
      host_addr  = addr;
      host_wdata = wdata;
      for (int lat = 1; lat <= 5 && !got; lat++) begin
         @(posedge clk); #1;
         if (host_ack) begin
            got = 1;
            chk("host_ram_we", {31'd0, ram_we}, {31'd0, we});
            if (we) begin
               chk("host_ram_addr", {18'd0, ram_addr}, {18'd0, addr});
               ref_mem[addr] = wdata;
            end else begin
               chk("host_rdata", {16'd0, host_rdata}, {16'd0, ref_mem[addr]});
            end
         end
      end
      chk("host_ack_within_5", {31'd0, got}, 32'd1);
      host_req = 1'b0;
      @(posedge clk); #1;
      chk("host_ack_single", {31'd0, host_ack}, 32'd0);
   endtask

   initial begin
      #4000000;
      $display("FAIL watchdog: run did not complete, %0d vectors applied", n_vec);
      $fatal(1, "timeout");
   end

   initial begin
      int lines [9];
      bit seen;
      logic [15:0] old;
      n_vec    = 0;
      n_err    = 0;
      exp_word = '0;
      exp_next = '0;

      // Fill RAM and reference image while the DUT sits in reset.
      init_we = 1'b1;
      for (int i = 0; i < 16384; i++) begin
         init_addr  = 14'(i);
         init_data  = (i == 162) ? 16'hA5C3 : 16'($urandom);
         ref_mem[i] = init_data;
         @(posedge clk); #1;
      end
      init_we = 1'b0;
      chk("rst_vid_word", {16'd0, vid_word}, 32'd0);
      chk("rst_vid_load", {31'd0, vid_load}, 32'd0);
      chk("rst_host_ack", {31'd0, host_ack}, 32'd0);
      chk("rst_host_rdata", {16'd0, host_rdata}, 32'd0);
      chk("rst_ram_we", {31'd0, ram_we}, 32'd0);
      chk("rst_ram_addr", {18'd0, ram_addr}, 32'd0);
      rst_n = 1'b1;

      // Mid-line fetch of line 5 word 2, handed off at xpos 47.
      tick(1'b0, 0, 5);
      tick(1'b1, 24, 5);
      chk("vid_rd_addr", {18'd0, ram_addr}, 32'd162);
      chk("vid_rd_we", {31'd0, ram_we}, 32'd0);
      repeat (6) tick(1'b0, 24, 5);
      tick(1'b1, 47, 5);
      chk("load_a5c3", {16'd0, vid_word}, 32'hA5C3);
      chk("load_pulse", {31'd0, vid_load}, 32'd1);
      tick(1'b0, 47, 5);
      chk("load_one_cycle", {31'd0, vid_load}, 32'd0);

      // Line 287 end: no fetch or handoff for the nonexistent line 288.
      repeat (2) tick(1'b0, 632, 287);
      tick(1'b1, 632, 287);
      chk("no_fetch_288", {18'd0, ram_addr}, 32'd0);
      repeat (6) tick(1'b0, 632, 287);
      tick(1'b1, 639, 287);
      chk("no_load_288", {31'd0, vid_load}, 32'd0);

      // Host write collides with the line-0 fetch at field end; video goes first.
      tick(1'b0, 632, 308);
      host_req = 1'b1; host_we = 1'b1; host_addr = 14'd100; host_wdata = 16'h1234;
      tick(1'b1, 632, 308);
      chk("coll_vidrd_addr", {18'd0, ram_addr}, 32'd0);
      chk("coll_ack_c1", {31'd0, host_ack}, 32'd0);
      tick(1'b0, 632, 308);
      chk("coll_ack_c2", {31'd0, host_ack}, 32'd0);
      tick(1'b0, 632, 308);
      chk("coll_ack_c3", {31'd0, host_ack}, 32'd0);
      tick(1'b0, 632, 308);
      chk("coll_ack_c4", {31'd0, host_ack}, 32'd1);
      chk("coll_ram_we", {31'd0, ram_we}, 32'd1);
      chk("coll_ram_addr", {18'd0, ram_addr}, 32'd100);
      host_req = 1'b0;
      ref_mem[100] = 16'h1234;
      repeat (6) tick(1'b0, 632, 308);
      tick(1'b1, 639, 308);
      chk("load_line0", {16'd0, vid_word}, {16'd0, ref_mem[0]});

      // Blanking read-back, then rdata must hold across a write.
      tick(1'b0, 0, 300);
      host_txn(1'b0, 14'd100, 16'd0);
      chk("rd_100", {16'd0, host_rdata}, 32'h1234);
      host_txn(1'b1, 14'd9400, 16'h5A5A);
      chk("rdata_hold", {16'd0, host_rdata}, 32'h1234);

      // Reset while HOST_WR is active: no write, no ack, everything cleared.
      old = ram[9300];
      host_req = 1'b1; host_we = 1'b1; host_addr = 14'd9300; host_wdata = 16'hBEEF;
      seen = 0;
      for (int i = 0; i < 6 && !seen; i++) begin
         @(posedge clk); #1;
         if (host_ack) seen = 1;
      end
      chk("rst_reach_hostwr", {31'd0, seen}, 32'd1);
      rst_n = 1'b0;
      #1;
      chk("rst_cycle_ram_we", {31'd0, ram_we}, 32'd0);
      chk("rst_cycle_ack", {31'd0, host_ack}, 32'd0);
      @(posedge clk); #1;
      chk("rst_no_write", {16'd0, ram[9300]}, {16'd0, old});
      chk("rst2_vid_word", {16'd0, vid_word}, 32'd0);
      chk("rst2_host_rdata", {16'd0, host_rdata}, 32'd0);
      chk("rst2_host_ack", {31'd0, host_ack}, 32'd0);
      chk("rst2_ram_addr", {18'd0, ram_addr}, 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      host_req = 1'b0;
      exp_word = '0;
      exp_next = '0;
      seen = 0;
      repeat (6) begin
         @(posedge clk); #1;
         if (host_ack) seen = 1;
      end
      chk("rst_dropped_no_ack", {31'd0, seen}, 32'd0);

      // Host request during the active field.
      tick(1'b0, 0, 100);
`ifdef TVARB_BLANK_ONLY_EN
      host_req = 1'b1; host_we = 1'b0; host_addr = 14'd100;
      seen = 0;
      repeat (20) begin
         tick(1'b0, 0, 100);
         if (host_ack) seen = 1;
      end
      chk("blank_only_stall", {31'd0, seen}, 32'd0);
      ypos = 9'd288;
      host_txn(1'b0, 14'd100, 16'd0);
`else
      host_txn(1'b0, 14'd100, 16'd0);
`endif

      // Randomized line sweeps with concurrent host traffic.
      lines = '{286, 287, 308, 0, 1, 0, 0, 0, 300};
      for (int i = 5; i < 8; i++) lines[i] = int'($urandom_range(2, 285));
      for (int li = 0; li < 9; li++) begin
         int y;
         y = lines[li];
         line_done = 0;
         fork
            begin
               sweep(y);
               line_done = 1;
            end
            begin
               logic        hw;
               logic [13:0] ha;
               if (host_allowed(y)) begin
                  while (!line_done) begin
                     repeat ($urandom_range(0, 12)) begin @(posedge clk); #1; end
                     if (!line_done) begin
                        hw = 1'($urandom_range(0, 1));
                        if (hw) begin
                           ha = 14'($urandom_range(9216, 16383));
                           wq.push_back(ha);
                        end else if (wq.size() > 0 && $urandom_range(0, 1) == 1) begin
                           ha = wq[$urandom_range(0, wq.size() - 1)];
                        end else begin
                           ha = 14'($urandom_range(0, 16383));
                        end
                        host_txn(hw, ha, 16'($urandom));
                     end
                  end
               end
            end
         join
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
